// File: rtl/dfe_pkg.sv
// Shared types and helpers for the multi-tap decision-feedback equalizer.
// Holds the FSM state type, width helpers for the accumulator and the
// equalized sample, and the coefficient saturation function.
package dfe_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } dfe_state_t;

    // Configuration address bus width.
    localparam int CFG_ADDR_W = 8;

    // Wide working width for coefficient arithmetic before saturation.
    localparam int WIDE_W = 64;

    // Feedback sum width: one coefficient times one level, summed over all taps.
    function automatic int acc_width(input int coef_w, input int pam_m, input int num_taps);
        return coef_w + $clog2(pam_m) + $clog2(num_taps) + 1;
    endfunction

    // Equalized sample width: wide enough for the shifted input minus the feedback sum.
    function automatic int eq_width(input int sig_w, input int coef_frac, input int acc_w);
        return (((sig_w + coef_frac) > acc_w) ? (sig_w + coef_frac) : acc_w) + 1;
    endfunction

    // Clamp a wide signed value into the signed range of coef_w bits.
    function automatic logic signed [WIDE_W-1:0] sat_coef(input logic signed [WIDE_W-1:0] value,
                                                          input int coef_w);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (coef_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (coef_w - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/dfe_if.sv
// Sample, configuration and decision signals of the equalizer in one bundle.
// The source side (master) drives samples and coefficient writes; the
// equalizer (slave) returns decisions, configuration status and its FSM state.
interface dfe_if #(
    parameter int SIG_W  = 8,
    parameter int COEF_W = 16,
    parameter int PAM_M  = 2
);
    import dfe_pkg::*;

    localparam int SYM_W = $clog2(PAM_M);

    // Strobe semantics: in_valid, cfg_wr and flush act only on the rising clock
    // edge where they are high; there is no back-pressure, so the equalizer
    // never stalls the source. out_valid and cfg_err are single-cycle strobes
    // whose companion data is meaningful only while the strobe is high.
    logic                            in_valid;
    logic signed [SIG_W-1:0]         in_data;
    logic                            flush;
    logic                            cfg_wr;
    logic        [CFG_ADDR_W-1:0]    cfg_addr;
    logic signed [COEF_W-1:0]        cfg_data;
    logic                            cfg_err;
    logic                            cfg_done;
    logic                            adapt_en;
    logic                            out_valid;
    logic        [SYM_W-1:0]         out_sym;
    logic signed [SYM_W:0]           out_level;
    logic signed [SIG_W+1:0]         out_eq;
    dfe_state_t                      state;

    modport master (
        output in_valid, in_data, flush, cfg_wr, cfg_addr, cfg_data, adapt_en,
        input  cfg_err, cfg_done, out_valid, out_sym, out_level, out_eq, state
    );

    modport slave (
        input  in_valid, in_data, flush, cfg_wr, cfg_addr, cfg_data, adapt_en,
        output cfg_err, cfg_done, out_valid, out_sym, out_level, out_eq, state
    );

endinterface

// File: rtl/dfe_slicer.sv
// PAM-M slicer: counts how many thresholds (2j-(M-2))*h0 the equalized sample
// reaches and maps that count to a symbol index and an odd signed level.
module dfe_slicer #(
    parameter int PAM_M  = 2,
    parameter int EQ_W   = 21,
    parameter int COEF_W = 16,
    localparam int SYM_W = $clog2(PAM_M)
) (
    input  logic signed [EQ_W-1:0]   eq_full,
    input  logic signed [COEF_W-1:0] h0,
    output logic        [SYM_W-1:0]  sym,
    output logic signed [SYM_W:0]    level
);

    // Threshold products need room for the factor (up to M-2) times h0.
    localparam int TW = EQ_W + COEF_W + 4;

    logic signed [TW-1:0] eq_ext;
    logic signed [TW-1:0] h0_ext;
    logic        [SYM_W-1:0] cnt;

    assign eq_ext = TW'(eq_full);
    assign h0_ext = TW'(h0);

    // Count thresholds met; a sample exactly on a threshold counts as above it.
    always_comb begin
        cnt = '0;
        for (int j = 0; j < PAM_M - 1; j++) begin
            if (eq_ext >= TW'(2 * j - (PAM_M - 2)) * h0_ext) begin
                cnt = cnt + SYM_W'(1);
            end
        end
    end

    assign sym   = cnt;
    assign level = (SYM_W + 1)'(2 * int'(cnt) - (PAM_M - 1));

endmodule

// File: rtl/dfe_multitap.sv
// Parametrised decision-feedback equalizer with N post-cursor taps and PAM-M
// slicing. Coefficients are written through the config port; once h0 and all
// taps have been written the block runs and produces one decision per sample
// in the same cycle the sample is accepted (registered outputs, no bubble).
// Optional sign-sign LMS tap adaptation is built when DFE_LMS_EN is defined.
module dfe_multitap
    import dfe_pkg::*;
#(
    parameter int SIG_W     = 8,
    parameter int NUM_TAPS  = 5,
    parameter int PAM_M     = 2,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 4,
    parameter int MU_STEP   = 1
) (
    input  logic  clk,
    input  logic  rstn,
    dfe_if.slave  bus
);

    localparam int SYM_W = $clog2(PAM_M);
    localparam int LVL_W = SYM_W + 1;
    localparam int ACC_W = acc_width(COEF_W, PAM_M, NUM_TAPS);
    localparam int EQ_W  = eq_width(SIG_W, COEF_FRAC, ACC_W);
    localparam int OUT_W = SIG_W + 2;

    localparam logic signed [LVL_W-1:0] LVL_FILL = '1;
    localparam logic signed [EQ_W-1:0]  OUT_MAX  = EQ_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EQ_W-1:0]  OUT_MIN  = EQ_W'(-(64'sd1 <<< (OUT_W - 1)));

    dfe_state_t state_q;
    dfe_state_t state_d;

    logic signed [COEF_W-1:0] coef     [0:NUM_TAPS];
    logic signed [LVL_W-1:0]  hist     [1:NUM_TAPS];
    logic signed [LVL_W-1:0]  hist_use [1:NUM_TAPS];
    logic        [NUM_TAPS:0] wr_map;

    logic                     cfg_ok;
    logic                     accept;
    logic signed [ACC_W-1:0]  isi;
    logic signed [EQ_W-1:0]   eq_full;
    logic signed [EQ_W-1:0]   eq_shift;
    logic signed [OUT_W-1:0]  eq_sat;
    logic        [SYM_W-1:0]  sym;
    logic signed [LVL_W-1:0]  lvl;

    assign cfg_ok = bus.cfg_wr && (bus.cfg_addr <= CFG_ADDR_W'(NUM_TAPS));
    assign accept = bus.in_valid && (state_q == RUN);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: first legal write leaves UNCFG; a fully written bitmap enters RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:   if (cfg_ok) state_d = LOAD;
            LOAD:    if (&wr_map) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = UNCFG;
        endcase
    end

    assign bus.cfg_done = (state_q == RUN);
    assign bus.state    = state_q;

    // A flush in the same cycle as a sample makes that sample see a filled history.
    always_comb begin
        for (int k = 1; k <= NUM_TAPS; k++) begin
            hist_use[k] = bus.flush ? LVL_FILL : hist[k];
        end
    end

    // Feedback sum over all post-cursor taps using the registered coefficients.
    always_comb begin
        isi = '0;
        for (int k = 1; k <= NUM_TAPS; k++) begin
            isi = isi + (ACC_W'(coef[k]) * ACC_W'(hist_use[k]));
        end
    end

    assign eq_full  = (EQ_W'(bus.in_data) <<< COEF_FRAC) - EQ_W'(isi);
    assign eq_shift = eq_full >>> COEF_FRAC;

    // Floor to integer LSBs, then clamp to the output range.
    always_comb begin
        if (eq_shift > OUT_MAX) begin
            eq_sat = OUT_W'(OUT_MAX);
        end else if (eq_shift < OUT_MIN) begin
            eq_sat = OUT_W'(OUT_MIN);
        end else begin
            eq_sat = eq_shift[OUT_W-1:0];
        end
    end

    dfe_slicer #(
        .PAM_M  (PAM_M),
        .EQ_W   (EQ_W),
        .COEF_W (COEF_W)
    ) u_slicer (
        .eq_full (eq_full),
        .h0      (coef[0]),
        .sym     (sym),
        .level   (lvl)
    );

`ifdef DFE_LMS_EN
    localparam int E_W = EQ_W + COEF_W + LVL_W + 1;

    logic signed [E_W-1:0]    err;
    logic                     lms_pend;
    logic                     lms_eneg;
    logic        [NUM_TAPS:1] lms_dneg;
    logic signed [COEF_W-1:0] lms_next [1:NUM_TAPS];
    logic signed [WIDE_W-1:0] lms_sum;

    assign err = E_W'(eq_full) - (E_W'(lvl) * E_W'(coef[0]));

    // Capture error and history signs with the decision; applied one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lms_pend <= 1'b0;
            lms_eneg <= 1'b0;
            lms_dneg <= '0;
        end else begin
            lms_pend <= accept && bus.adapt_en && (err != '0);
            lms_eneg <= err[E_W-1];
            for (int k = 1; k <= NUM_TAPS; k++) begin
                lms_dneg[k] <= hist_use[k][LVL_W-1];
            end
        end
    end

    // Sign-sign step per tap, saturated to the coefficient range.
    always_comb begin
        lms_sum = '0;
        for (int k = 1; k <= NUM_TAPS; k++) begin
            lms_sum = WIDE_W'(coef[k]) +
                      ((lms_eneg ^ lms_dneg[k]) ? -WIDE_W'(MU_STEP) : WIDE_W'(MU_STEP));
            lms_sum = sat_coef(lms_sum, COEF_W);
            lms_next[k] = lms_sum[COEF_W-1:0];
        end
    end
`else
    logic unused_adapt;
    localparam int unused_mu = MU_STEP;
    assign unused_adapt = bus.adapt_en;
`endif

    // Coefficient store and write bitmap; a config write beats an adaptation step.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k <= NUM_TAPS; k++) begin
                coef[k] <= '0;
            end
            wr_map <= '0;
        end else begin
`ifdef DFE_LMS_EN
            if (lms_pend) begin
                for (int k = 1; k <= NUM_TAPS; k++) begin
                    coef[k] <= lms_next[k];
                end
            end
`endif
            for (int k = 0; k <= NUM_TAPS; k++) begin
                if (cfg_ok && (bus.cfg_addr == CFG_ADDR_W'(k))) begin
                    coef[k]   <= bus.cfg_data;
                    wr_map[k] <= 1'b1;
                end
            end
        end
    end

    // Decision history: shift in each new level; a lone flush refills with -1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 1; k <= NUM_TAPS; k++) begin
                hist[k] <= LVL_FILL;
            end
        end else if (accept) begin
            hist[1] <= lvl;
            for (int k = 2; k <= NUM_TAPS; k++) begin
                hist[k] <= hist_use[k-1];
            end
        end else if (bus.flush) begin
            for (int k = 1; k <= NUM_TAPS; k++) begin
                hist[k] <= LVL_FILL;
            end
        end
    end

    // Registered decision outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_valid <= 1'b0;
            bus.out_sym   <= '0;
            bus.out_level <= '0;
            bus.out_eq    <= '0;
        end else begin
            bus.out_valid <= accept;
            if (accept) begin
                bus.out_sym   <= sym;
                bus.out_level <= lvl;
                bus.out_eq    <= eq_sat;
            end
        end
    end

    // One-cycle error pulse for writes beyond the last tap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_err <= bus.cfg_wr && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_dfe_multitap.sv
// Directed bench for dfe_multitap: a PAM2 instance and a PAM4 instance,
// both with three taps and four fractional coefficient bits, sharing one
// stimulus stream. Expected values are worked out by hand in the comments.
module tb_dfe_multitap;
    import dfe_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    dfe_if #(.SIG_W(8), .COEF_W(16), .PAM_M(2)) bus2 ();
    dfe_if #(.SIG_W(8), .COEF_W(16), .PAM_M(4)) bus4 ();

    assign bus4.in_valid = bus2.in_valid;
    assign bus4.in_data  = bus2.in_data;
    assign bus4.flush    = bus2.flush;
    assign bus4.cfg_wr   = bus2.cfg_wr;
    assign bus4.cfg_addr = bus2.cfg_addr;
    assign bus4.cfg_data = bus2.cfg_data;
    assign bus4.adapt_en = bus2.adapt_en;

    dfe_multitap #(
        .SIG_W(8), .NUM_TAPS(3), .PAM_M(2), .COEF_W(16), .COEF_FRAC(4), .MU_STEP(1)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    dfe_multitap #(
        .SIG_W(8), .NUM_TAPS(3), .PAM_M(4), .COEF_W(16), .COEF_FRAC(4), .MU_STEP(1)
    ) u_dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic signed [15:0] data);
        bus2.cfg_wr   = 1'b1;
        bus2.cfg_addr = addr;
        bus2.cfg_data = data;
        tick();
        bus2.cfg_wr   = 1'b0;
    endtask

    task automatic send(input logic signed [7:0] data);
        bus2.in_valid = 1'b1;
        bus2.in_data  = data;
        tick();
    endtask

    task automatic idle();
        bus2.in_valid = 1'b0;
    endtask

    task automatic check_out2(input string tag, input int sym, input int lvl, input int eq);
        check({tag, "_valid"}, bus2.out_valid, 1);
        check({tag, "_sym"},   bus2.out_sym,   sym);
        check({tag, "_level"}, bus2.out_level, lvl);
        check({tag, "_eq"},    bus2.out_eq,    eq);
    endtask

    task automatic check_out4(input string tag, input int sym, input int lvl);
        check({tag, "_sym4"},   bus4.out_sym,   sym);
        check({tag, "_level4"}, bus4.out_level, lvl);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn          = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        bus2.flush    = 1'b0;
        bus2.cfg_wr   = 1'b0;
        bus2.cfg_addr = '0;
        bus2.cfg_data = '0;
        bus2.adapt_en = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_out_valid", bus2.out_valid, 0);
        check("rst_out_eq",    bus2.out_eq,    0);
        check("rst_out_level", bus2.out_level, 0);
        check("rst_out_sym",   bus2.out_sym,   0);
        check("rst_cfg_done",  bus2.cfg_done,  0);
        check("rst_cfg_err",   bus2.cfg_err,   0);
        check("rst_state",     bus2.state,     UNCFG);
        rstn = 1'b1;

        // A sample before configuration is dropped.
        send(8'sd40);
        idle();
        check("precfg_no_out", bus2.out_valid, 0);

        // Address 9 is beyond tap 3: error pulse, FSM stays UNCFG.
        cfg_write(8'd9, 16'sd123);
        check("cfg_err_pulse", bus2.cfg_err, 1);
        check("cfg_err_state", bus2.state,   UNCFG);
        tick();
        check("cfg_err_clear", bus2.cfg_err, 0);

        // h0 = 512 (32 LSB), taps 0; a sample during LOAD is dropped.
        cfg_write(8'd0, 16'sd512);
        check("load_state", bus2.state, LOAD);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 8'sd40;
        cfg_write(8'd1, 16'sd0);
        idle();
        check("load_no_out", bus2.out_valid, 0);
        cfg_write(8'd2, 16'sd0);
        cfg_write(8'd3, 16'sd0);
        check("done_not_yet", bus2.cfg_done, 0);
        tick();
        check("done_one_later", bus2.cfg_done, 1);
        check("run_state",      bus2.state,    RUN);

        // Basic slice with zero taps: sign decides, out_eq equals input.
        send(8'sd40);
        check_out2("slice_pos", 1, 1, 40);
        send(-8'sd3);
        check_out2("slice_neg", 0, -1, -3);

        // PAM4, h0=512: thresholds on eq_full are -1024, 0, +1024 (input -64, 0, +64).
        send(8'sd70);
        check_out4("pam4_70", 3, 3);
        check("pam4_70_eq", bus4.out_eq, 70);
        send(8'sd20);
        check_out4("pam4_20", 2, 1);
        send(-8'sd5);
        check_out4("pam4_m5", 1, -1);
        send(-8'sd70);
        check_out4("pam4_m70", 0, -3);
        send(8'sd64);
        check_out4("pam4_thr64", 3, 3);
        send(8'sd63);
        check_out4("pam4_thr63", 2, 1);
        idle();

        // ISI cancel, c1 = 256 (16 LSB). Flushed first sample: 640+256 -> 56.
        // Second sample sees d1=+1: 160-256 = -96 -> -6.
        cfg_write(8'd1, 16'sd256);
        bus2.flush = 1'b1;
        send(8'sd40);
        bus2.flush = 1'b0;
        check_out2("isi_flush_first", 1, 1, 56);
        send(8'sd10);
        check_out2("isi_cancel", 0, -1, -6);

        // Write c1=0 with a sample: old c1 with d1=-1 gives 160+256 -> 26.
        bus2.cfg_wr   = 1'b1;
        bus2.cfg_addr = 8'd1;
        bus2.cfg_data = 16'sd0;
        send(8'sd10);
        bus2.cfg_wr   = 1'b0;
        check_out2("cfg_same_cycle_old", 1, 1, 26);
        send(8'sd10);
        check_out2("cfg_new_applied", 1, 1, 10);
        idle();

        // Output saturation with c1 = 32767.
        // 2032+32767 = 34799 -> 2174 -> 511; -2048-32767 = -34815 -> -2176 -> -512.
        cfg_write(8'd1, 16'sd32767);
        bus2.flush = 1'b1;
        send(8'sd127);
        bus2.flush = 1'b0;
        check_out2("sat_pos", 1, 1, 511);
        send(-8'sd128);
        check_out2("sat_neg", 0, -1, -512);
        idle();

        // Floor rounding with c1 = 8 (half an LSB): eq_full +8 -> 0, -8 -> -1.
        cfg_write(8'd1, 16'sd8);
        send(8'sd0);
        check_out2("floor_pos", 1, 1, 0);
        send(8'sd0);
        check_out2("floor_neg", 0, -1, -1);
        send(8'sd0);
        check_out2("floor_pos2", 1, 1, 0);
        idle();

        // Flush alone clears d1=+1 back to -1, so eq_full is +8 again.
        bus2.flush = 1'b1;
        tick();
        bus2.flush = 1'b0;
        send(8'sd0);
        check_out2("flush_alone", 1, 1, 0);

        // Async reset mid-stream clears outputs without a clock edge.
        send(8'sd40);
        check("pre_reset_valid", bus2.out_valid, 1);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", bus2.out_valid, 0);
        check("arst_out_eq",    bus2.out_eq,    0);
        check("arst_out_level", bus2.out_level, 0);
        check("arst_cfg_done",  bus2.cfg_done,  0);
        check("arst_state",     bus2.state,     UNCFG);
        check("arst_state4",    bus4.state,     UNCFG);
        idle();
        tick();
        rstn = 1'b1;

`ifdef DFE_LMS_EN
        // Sign-sign LMS: h0=512, taps 0, constant input 48 (eq_full 768, e > 0).
        // c1 after each later edge: -1, 0, +1, +2; a same-cycle write wins.
        cfg_write(8'd0, 16'sd512);
        cfg_write(8'd1, 16'sd0);
        cfg_write(8'd2, 16'sd0);
        cfg_write(8'd3, 16'sd0);
        tick();
        bus2.adapt_en = 1'b1;
        bus2.flush    = 1'b1;
        send(8'sd48);
        bus2.flush    = 1'b0;
        send(8'sd48);
        check("lms_c1_s1", u_dut.coef[1], -1);
        send(8'sd48);
        check("lms_c1_s2", u_dut.coef[1], 0);
        send(8'sd48);
        check("lms_c1_s3", u_dut.coef[1], 1);
        send(8'sd48);
        check("lms_c1_s4", u_dut.coef[1], 2);
        bus2.cfg_wr   = 1'b1;
        bus2.cfg_addr = 8'd1;
        bus2.cfg_data = 16'sd100;
        send(8'sd48);
        bus2.cfg_wr   = 1'b0;
        check("lms_cfg_wins", u_dut.coef[1], 100);
        idle();
        bus2.adapt_en = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
